// File: rtl/sd_sector_responder.sv
// SD sector responder: moves one 512-byte sector per request between an SD-style
// initiator buffer and a byte-wide backing store with a ready handshake.
module sd_sector_responder #(
   parameter int ACK_DELAY = 4,
   parameter int DIN_LAT   = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [31:0] sd_lba,
   input  logic        sd_rd,
   input  logic        sd_wr,
   output logic        sd_ack,
   output logic [8:0]  sd_buff_addr,
   output logic [7:0]  sd_buff_dout,
   output logic        sd_buff_wr,
   input  logic [7:0]  sd_buff_din,
   output logic [40:0] st_addr,
   output logic        st_rd,
   output logic        st_wr,
   output logic [7:0]  st_wdata,
   input  logic [7:0]  st_rdata,
   input  logic        st_ready,
   output logic [15:0] sectors
);
   typedef enum logic [2:0] {
      IDLE, DELAY, RD_FETCH, RD_PUT, WR_ADDR, WR_LAT, WR_STORE, GAP
   } state_t;

   localparam logic [3:0] ACK_LAST = 4'(ACK_DELAY - 1);
   localparam logic [3:0] LAT_LAST = 4'(DIN_LAT - 1);
   localparam logic [8:0] IDX_LAST = 9'd511;

   state_t      state_q, state_d;
   logic [31:0] lba_q, lba_d;
   logic [8:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        is_rd_q, is_rd_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [15:0] sectors_q, sectors_d;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         lba_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         is_rd_q   <= 1'b0;
         rdata_q   <= '0;
         wdata_q   <= '0;
         sectors_q <= '0;
      end else begin
         lba_q     <= lba_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         is_rd_q   <= is_rd_d;
         rdata_q   <= rdata_d;
         wdata_q   <= wdata_d;
         sectors_q <= sectors_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (sd_rd || sd_wr) state_d = DELAY;
         DELAY:    if (cnt_q == ACK_LAST) state_d = is_rd_q ? RD_FETCH : WR_ADDR;
         RD_FETCH: if (st_ready) state_d = RD_PUT;
         RD_PUT:   state_d = (idx_q == IDX_LAST) ? GAP : RD_FETCH;
         WR_ADDR:  state_d = WR_LAT;
         WR_LAT:   if (cnt_q == LAT_LAST) state_d = WR_STORE;
         WR_STORE: if (st_ready) state_d = (idx_q == IDX_LAST) ? GAP : WR_ADDR;
         GAP:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // cnt_q is shared: it times the ack delay and, per byte, the buffer read latency.
   always_comb begin
      lba_d     = lba_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      is_rd_d   = is_rd_q;
      rdata_d   = rdata_q;
      wdata_d   = wdata_q;
      sectors_d = sectors_q;
      case (state_q)
         IDLE: begin
            if (sd_rd || sd_wr) begin
               lba_d   = sd_lba;
               is_rd_d = sd_rd;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         DELAY:    cnt_d = cnt_q + 4'd1;
         RD_FETCH: if (st_ready) rdata_d = st_rdata;
         RD_PUT:   if (idx_q != IDX_LAST) idx_d = idx_q + 9'd1;
         WR_ADDR:  cnt_d = '0;
         WR_LAT: begin
            if (cnt_q == LAT_LAST) wdata_d = sd_buff_din;
            else cnt_d = cnt_q + 4'd1;
         end
         WR_STORE: if (st_ready && (idx_q != IDX_LAST)) idx_d = idx_q + 9'd1;
         GAP:      sectors_d = sectors_q + 16'd1;
         default:  ;
      endcase
   end

   always_comb begin
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      st_rd      = 1'b0;
      st_wr      = 1'b0;
      case (state_q)
         RD_FETCH: begin
            sd_ack = 1'b1;
            st_rd  = 1'b1;
         end
         RD_PUT: begin
            sd_ack     = 1'b1;
            sd_buff_wr = 1'b1;
         end
         WR_ADDR, WR_LAT: sd_ack = 1'b1;
         WR_STORE: begin
            sd_ack = 1'b1;
            st_wr  = 1'b1;
         end
         default: ;
      endcase
   end

   assign sd_buff_addr = idx_q;
   assign sd_buff_dout = rdata_q;
   assign st_addr      = {lba_q, idx_q};
   assign st_wdata     = wdata_q;
   assign sectors      = sectors_q;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: two instances (default timing, and DIN_LAT=3 with
// ACK_DELAY=2) against a behavioural store/initiator model.
module tb_sd_sector_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] sd_lba [2];
   logic        sd_rd [2];
   logic        sd_wr [2];
   logic        sd_ack [2];
   logic [8:0]  sd_buff_addr [2];
   logic [7:0]  sd_buff_dout [2];
   logic        sd_buff_wr [2];
   logic [7:0]  sd_buff_din [2];
   logic [40:0] st_addr [2];
   logic        st_rd [2];
   logic        st_wr [2];
   logic [7:0]  st_wdata [2];
   logic [7:0]  st_rdata [2];
   logic        st_ready [2];
   logic [15:0] sectors [2];

   logic        spurious [2];
   bit          fixed_lat [2];
   logic [7:0]  ibuf [2][512];
   int          exp_sectors [2];
   int          checks = 0;
   int          failures = 0;

   // transactions seen by observe()
   logic [8:0]  bw_addr [$];
   logic [7:0]  bw_data [$];
   bit          sa_wr [$];
   logic [40:0] sa_addr [$];
   logic [7:0]  sa_wdata [$];
   int          bw_noack;

   // backing-store contents: sector 5 holds n, others a deterministic mix of lba and n
   function automatic logic [7:0] store_byte(input logic [31:0] lba, input logic [8:0] n);
      if (lba == 32'd5) return n[7:0];
      return (n[7:0] * lba[7:0]) ^ lba[15:8] ^ 8'h5A;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic       rdy;
      logic [7:0] rdat;
      int         cnt;
      int         lat;
      logic [7:0] pipe [3];

      sd_sector_responder #(
         .ACK_DELAY(gi == 0 ? 4 : 2),
         .DIN_LAT  (gi == 0 ? 1 : 3)
      ) u_dut (
         .clk_sys     (clk),
         .reset       (reset),
         .sd_lba      (sd_lba[gi]),
         .sd_rd       (sd_rd[gi]),
         .sd_wr       (sd_wr[gi]),
         .sd_ack      (sd_ack[gi]),
         .sd_buff_addr(sd_buff_addr[gi]),
         .sd_buff_dout(sd_buff_dout[gi]),
         .sd_buff_wr  (sd_buff_wr[gi]),
         .sd_buff_din (sd_buff_din[gi]),
         .st_addr     (st_addr[gi]),
         .st_rd       (st_rd[gi]),
         .st_wr       (st_wr[gi]),
         .st_wdata    (st_wdata[gi]),
         .st_rdata    (st_rdata[gi]),
         .st_ready    (st_ready[gi]),
         .sectors     (sectors[gi])
      );

      // store model: one-cycle ready pulse 'lat' cycles after a strobe is seen
      always @(negedge clk or posedge reset) begin
         if (reset) begin
            rdy  <= 1'b0;
            cnt  <= 0;
            lat  <= 2;
            rdat <= 8'h00;
         end else if (rdy) begin
            rdy <= 1'b0;
            cnt <= 0;
            lat <= fixed_lat[gi] ? 2 : int'($urandom_range(4, 1));
         end else if (st_rd[gi] || st_wr[gi]) begin
            if (cnt + 1 >= lat) begin
               rdy  <= 1'b1;
               rdat <= store_byte(st_addr[gi][40:9], st_addr[gi][8:0]);
            end
            cnt <= cnt + 1;
         end
      end
      assign st_ready[gi] = rdy | spurious[gi];
      assign st_rdata[gi] = rdat;

      // initiator buffer: data appears DIN_LAT cycles after the address
      always @(posedge clk) begin
         pipe[0] <= ibuf[gi][sd_buff_addr[gi]];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign sd_buff_din[gi] = pipe[gi == 0 ? 0 : 2];
   end

   task automatic start_req(input int u, input logic rd, input logic wr, input logic [31:0] lba);
      @(negedge clk);
      sd_lba[u] = lba;
      sd_rd[u]  = rd;
      sd_wr[u]  = wr;
   endtask

   // Samples each cycle until sd_ack has been high and falls; records buffer strobes
   // and the start of every store access. Request is dropped after 'pulse' cycles.
   task automatic observe(input int u, input int pulse, output int ack_rise, output bit timed_out);
      int cyc = 0;
      bit seen = 1'b0;
      bit prev_acc = 1'b0;
      bit acc;
      ack_rise = -1;
      timed_out = 1'b0;
      bw_noack = 0;
      bw_addr.delete(); bw_data.delete();
      sa_wr.delete(); sa_addr.delete(); sa_wdata.delete();
      forever begin
         @(posedge clk); #1;
         if (cyc + 1 >= pulse) begin
            sd_rd[u] = 1'b0;
            sd_wr[u] = 1'b0;
         end
         if (sd_ack[u] && !seen) begin
            seen = 1'b1;
            ack_rise = cyc;
         end
         if (sd_buff_wr[u]) begin
            bw_addr.push_back(sd_buff_addr[u]);
            bw_data.push_back(sd_buff_dout[u]);
            if (!sd_ack[u]) bw_noack++;
         end
         acc = st_rd[u] | st_wr[u];
         if (acc && !prev_acc) begin
            sa_wr.push_back(st_wr[u]);
            sa_addr.push_back(st_addr[u]);
            sa_wdata.push_back(st_wdata[u]);
         end
         prev_acc = acc;
         if (seen && !sd_ack[u]) break;
         cyc++;
         if (cyc > 8000) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({sd_ack[0], sd_buff_wr[0], st_rd[0], st_wr[0]} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_strobes got=%b want=0000", {sd_ack[0], sd_buff_wr[0], st_rd[0], st_wr[0]});
      end
      checks++;
      if ({sd_buff_addr[0], sd_buff_dout[0], st_wdata[0]} !== 25'd0) begin
         failures++;
         $display("FAIL reset_buff got=%h want=0", {sd_buff_addr[0], sd_buff_dout[0], st_wdata[0]});
      end
      checks++;
      if (st_addr[0] !== 41'd0 || sectors[0] !== 16'd0) begin
         failures++;
         $display("FAIL reset_addr_sectors got=%h/%0d want=0/0", st_addr[0], sectors[0]);
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk); spurious[0] = 1'b1;
      @(negedge clk); spurious[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({sd_ack[0], st_rd[0], st_wr[0], sd_buff_wr[0]} !== 4'b0000 || sectors[0] !== 16'd0) begin
            failures++;
            $display("FAIL idle_spurious_ready got=%b sectors=%0d want=0000 sectors=0",
                     {sd_ack[0], st_rd[0], st_wr[0], sd_buff_wr[0]}, sectors[0]);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_read_sector5();
      int ar; bit to; int nw = 0;
      fixed_lat[0] = 1'b1;
      start_req(0, 1'b1, 1'b0, 32'd5);
      observe(0, 1, ar, to);
      checks++;
      if (to) begin failures++; $display("FAIL read5_timeout got=timeout want=done"); end
      checks++;
      if (ar !== 4) begin failures++; $display("FAIL read5_ack_rise got=%0d want=4", ar); end
      checks++;
      if (bw_addr.size() !== 512) begin failures++; $display("FAIL read5_strobes got=%0d want=512", bw_addr.size()); end
      for (int n = 0; n < bw_addr.size() && n < 512; n++) begin
         checks++;
         if (bw_addr[n] !== 9'(n) || bw_data[n] !== 8'(n)) begin
            failures++;
            $display("FAIL read5_byte idx=%0d got=%0d/%h want=%0d/%h", n, bw_addr[n], bw_data[n], n, 8'(n));
         end
      end
      for (int n = 0; n < sa_addr.size(); n++) begin
         if (sa_wr[n]) nw++;
         checks++;
         if (sa_addr[n] !== {32'd5, 9'(n)}) begin
            failures++;
            $display("FAIL read5_st_addr idx=%0d got=%h want=%h", n, sa_addr[n], {32'd5, 9'(n)});
         end
      end
      checks++;
      if (nw !== 0 || sa_addr.size() !== 512) begin
         failures++;
         $display("FAIL read5_accesses got=%0d writes=%0d want=512 writes=0", sa_addr.size(), nw);
      end
      checks++;
      if (bw_noack !== 0) begin failures++; $display("FAIL read5_wr_without_ack got=%0d want=0", bw_noack); end
      @(posedge clk); #1;
      exp_sectors[0]++;
      checks++;
      if (sectors[0] !== 16'(exp_sectors[0])) begin
         failures++;
         $display("FAIL read5_sectors got=%0d want=%0d", sectors[0], exp_sectors[0]);
      end
      $display("test_read_sector5 done ack_rise=%0d strobes=%0d", ar, bw_addr.size());
   endtask

   // Runs one transfer with random store latency and checks every byte against the model.
   task automatic xfer_check(input int u, input string tag, input logic rd, input logic wr,
                             input logic [31:0] lba, input int pulse, input int exp_rise);
      int ar; bit to; int nw = 0;
      logic [40:0] ea;
      start_req(u, rd, wr, lba);
      observe(u, pulse, ar, to);
      checks++;
      if (to || ar !== exp_rise) begin
         failures++;
         $display("FAIL %s_ack_rise got=%0d timeout=%0b want=%0d", tag, ar, to, exp_rise);
      end
      checks++;
      if (sa_addr.size() !== 512 || bw_addr.size() !== (rd ? 512 : 0)) begin
         failures++;
         $display("FAIL %s_counts got=st:%0d buff:%0d want=st:512 buff:%0d", tag,
                  sa_addr.size(), bw_addr.size(), rd ? 512 : 0);
      end
      for (int n = 0; n < sa_addr.size(); n++) begin
         if (sa_wr[n]) nw++;
         ea = {lba, 9'(n)};
         checks++;
         if (sa_addr[n] !== ea || sa_wr[n] !== !rd || (!rd && sa_wdata[n] !== ibuf[u][n])) begin
            failures++;
            $display("FAIL %s_store idx=%0d got=%h wr=%0b data=%h want=%h wr=%0b data=%h", tag, n,
                     sa_addr[n], sa_wr[n], sa_wdata[n], ea, !rd, ibuf[u][n]);
         end
      end
      for (int n = 0; n < bw_addr.size(); n++) begin
         checks++;
         if (bw_addr[n] !== 9'(n) || bw_data[n] !== store_byte(lba, 9'(n))) begin
            failures++;
            $display("FAIL %s_buff idx=%0d got=%0d/%h want=%0d/%h", tag, n, bw_addr[n], bw_data[n],
                     n, store_byte(lba, 9'(n)));
         end
      end
      checks++;
      if (rd && nw !== 0) begin failures++; $display("FAIL %s_no_write got=%0d want=0", tag, nw); end
      @(posedge clk); #1;
      exp_sectors[u]++;
      checks++;
      if (sectors[u] !== 16'(exp_sectors[u])) begin
         failures++;
         $display("FAIL %s_sectors got=%0d want=%0d", tag, sectors[u], exp_sectors[u]);
      end
      $display("%s done lba=%h rd=%0b wr=%0b accesses=%0d strobes=%0d", tag, lba, rd, wr,
               sa_addr.size(), bw_addr.size());
   endtask

   task automatic test_write();
      fixed_lat[0] = 1'b0;
      for (int n = 0; n < 512; n++) ibuf[0][n] = ~8'(n);
      xfer_check(0, "write12", 1'b0, 1'b1, 32'h12, 3, 4);
   endtask

   task automatic test_simultaneous();
      xfer_check(0, "simultaneous", 1'b1, 1'b1, $urandom, 2, 4);
   endtask

   task automatic test_random();
      logic rd;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 512; n++) ibuf[0][n] = 8'($urandom);
         rd = 1'($urandom);
         xfer_check(0, "random", rd, !rd, $urandom, int'($urandom_range(8, 1)), 4);
      end
   endtask

   task automatic test_back_to_back();
      int ar; bit to; int low = 1;
      logic [31:0] lba1 = $urandom;
      logic [31:0] lba2 = $urandom;
      start_req(0, 1'b1, 1'b0, lba1);
      observe(0, 1, ar, to);
      sd_lba[0] = lba2;
      sd_rd[0]  = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (sd_ack[0]) break;
         low++;
      end
      sd_rd[0] = 1'b0;
      checks++;
      if (to || low !== 6) begin
         failures++;
         $display("FAIL b2b_ack_low got=%0d timeout=%0b want=6", low, to);
      end
      exp_sectors[0]++;
      checks++;
      if (sectors[0] !== 16'(exp_sectors[0])) begin
         failures++;
         $display("FAIL b2b_sectors_mid got=%0d want=%0d", sectors[0], exp_sectors[0]);
      end
      observe(0, 0, ar, to);
      checks++;
      if (to || bw_addr.size() !== 512) begin
         failures++;
         $display("FAIL b2b_second_strobes got=%0d timeout=%0b want=512", bw_addr.size(), to);
      end
      for (int n = 0; n < bw_addr.size(); n++) begin
         checks++;
         if (bw_addr[n] !== 9'(n) || bw_data[n] !== store_byte(lba2, 9'(n))) begin
            failures++;
            $display("FAIL b2b_buff idx=%0d got=%0d/%h want=%0d/%h", n, bw_addr[n], bw_data[n],
                     n, store_byte(lba2, 9'(n)));
         end
      end
      @(posedge clk); #1;
      exp_sectors[0]++;
      checks++;
      if (sectors[0] !== 16'(exp_sectors[0])) begin
         failures++;
         $display("FAIL b2b_sectors_end got=%0d want=%0d", sectors[0], exp_sectors[0]);
      end
      $display("test_back_to_back done ack_low=%0d", low);
   endtask

   task automatic test_reset_mid_write();
      bit found = 1'b0;
      for (int n = 0; n < 512; n++) ibuf[0][n] = 8'($urandom);
      start_req(0, 1'b0, 1'b1, $urandom);
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #1;
         sd_wr[0] = 1'b0;
         if (st_wr[0] && st_addr[0][8:0] == 9'd200) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin failures++; $display("FAIL midreset_reach200 got=timeout want=byte200"); end
      reset = 1'b1;
      #1;
      exp_sectors[0] = 0;
      exp_sectors[1] = 0;
      checks++;
      if ({sd_ack[0], sd_buff_wr[0], st_rd[0], st_wr[0]} !== 4'b0000) begin
         failures++;
         $display("FAIL midreset_strobes got=%b want=0000", {sd_ack[0], sd_buff_wr[0], st_rd[0], st_wr[0]});
      end
      checks++;
      if (st_addr[0] !== 41'd0 || st_wdata[0] !== 8'd0 || sd_buff_addr[0] !== 9'd0 ||
          sd_buff_dout[0] !== 8'd0 || sectors[0] !== 16'd0) begin
         failures++;
         $display("FAIL midreset_values got=%h/%h/%h/%h/%0d want=0", st_addr[0], st_wdata[0],
                  sd_buff_addr[0], sd_buff_dout[0], sectors[0]);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({sd_ack[0], st_rd[0], st_wr[0]} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_quiet got=%b want=000", {sd_ack[0], st_rd[0], st_wr[0]});
         end
      end
      xfer_check(0, "after_reset", 1'b0, 1'b1, $urandom, 1, 4);
   endtask

   task automatic test_din_lat3();
      fixed_lat[1] = 1'b0;
      ibuf[1][0] = 8'($urandom);
      for (int n = 1; n < 512; n++) begin
         ibuf[1][n] = 8'($urandom);
         if (ibuf[1][n] == ibuf[1][n-1]) ibuf[1][n] = ibuf[1][n] + 8'd1;
      end
      xfer_check(1, "din_lat3", 1'b0, 1'b1, $urandom, 2, 2);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         sd_lba[u] = '0;
         sd_rd[u] = 1'b0;
         sd_wr[u] = 1'b0;
         spurious[u] = 1'b0;
         fixed_lat[u] = 1'b1;
         exp_sectors[u] = 0;
         for (int n = 0; n < 512; n++) ibuf[u][n] = 8'h00;
      end
      test_reset();
      test_read_sector5();
      test_write();
      test_simultaneous();
      test_random();
      test_back_to_back();
      test_reset_mid_write();
      test_din_lat3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
